// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared types and defaults for the serial-to-parallel deserializer
package deserializer_pkg;

  localparam int DESER_DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE,
    COLLECT
  } deser_state_e;

endpackage

// File: rtl/deserializer_shift_reg.sv
// rtl/deserializer_shift_reg.sv - bit-insertion shift register with clear and length-based justification
module deserializer_shift_reg
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = DESER_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int LEN_W     = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic             i_clear,
  input  logic [LEN_W-1:0] i_len,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;
  logic [LEN_W-1:0] w_amt;

  assign w_next = i_shift ? w_shifted : r_sr;
  assign w_amt  = LEN_W'(WIDTH) - i_len;

  // Stale bits from an earlier word are pushed out by the justify shift, so no masking is needed.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], i_bit};
      assign o_word    = w_next << w_amt;
    end else begin : g_lsb_first
      assign w_shifted = {i_bit, r_sr[WIDTH-1:1]};
      assign o_word    = w_next >> w_amt;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_srst) begin
    if (i_srst) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= w_shifted;
    end
  end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel deserializer; DESERIALIZER_FLUSH_EN adds flush_i/data_len_o
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = DESER_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               data_i,
  input  logic               data_val_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               data_val_o,
  output logic               busy_o
`ifdef DESERIALIZER_FLUSH_EN
  ,
  input  logic               flush_i,
  output logic [$clog2(WIDTH):0] data_len_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  deser_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len;
  logic             w_full;
  logic             w_flush;
  logic             w_emit;
  logic [WIDTH-1:0] w_word;

  // Bit count including the bit accepted on this edge, if any.
  assign w_len  = r_cnt + CNT_W'(data_val_i);
  assign w_full = data_val_i && (r_cnt == LAST_IDX);

`ifdef DESERIALIZER_FLUSH_EN
  assign w_flush = flush_i && (w_len != '0);
`else
  assign w_flush = 1'b0;
`endif

  assign w_emit = w_full || w_flush;
  assign busy_o = (r_state == COLLECT);

  deserializer_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .LEN_W    (CNT_W)
  ) u_shift_reg (
    .i_clk  (clk_i),
    .i_srst (srst_i),
    .i_shift(data_val_i),
    .i_bit  (data_i),
    .i_clear(w_emit),
    .i_len  (w_len),
    .o_word (w_word)
  );

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
`ifdef DESERIALIZER_FLUSH_EN
      data_len_o <= '0;
`endif
    end else begin
      data_val_o <= w_emit;
      if (w_emit) begin
        data_o  <= w_word;
        r_cnt   <= '0;
        r_state <= IDLE;
`ifdef DESERIALIZER_FLUSH_EN
        data_len_o <= w_len;
`endif
      end else if (data_val_i) begin
        r_cnt   <= w_len;
        r_state <= COLLECT;
      end
    end
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 32, output word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 means the first received bit lands in data_o[WIDTH-1], 0 means it lands in data_o[0].
REQ-003 Port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port srst_i, input, 1, asynchronous active-high reset.
REQ-005 Port data_i, input, 1, serial data bit.
REQ-006 Port data_val_i, input, 1, data_i is accepted on any rising edge where this is high; there is no backpressure.
REQ-007 Port data_o, output, WIDTH, assembled parallel word; feeds the data_i input of bit_population_counter.
REQ-008 Port data_val_o, output, 1, single-cycle strobe qualifying data_o; feeds data_val_i of bit_population_counter.
REQ-009 Port busy_o, output, 1, high while a partial word (1..WIDTH-1 bits) is held.

Function
REQ-010 An internal bit counter cnt of width $clog2(WIDTH)+1 SHALL count accepted bits 0..WIDTH-1.
REQ-011 FSM states: IDLE (cnt==0) and COLLECT (cnt>0); IDLE->COLLECT on an accepted bit; COLLECT->IDLE on acceptance of bit WIDTH, or on flush (REQ-020).
REQ-012 Each accepted bit is placed by shift: MSB_FIRST=1 shifts left with insertion at bit 0; MSB_FIRST=0 shifts right with insertion at bit WIDTH-1.
REQ-013 On acceptance of the WIDTH-th bit, cnt SHALL wrap to 0; on the next edge data_o holds the full word and data_val_o is high for exactly one cycle (latency: 1 cycle after the last bit).
REQ-014 Back-to-back words SHALL need no idle cycle; a bit accepted in the cycle after completion is bit 1 of the next word.
REQ-015 data_o SHALL hold its last value while data_val_o is low; it changes only on the cycle data_val_o rises.
REQ-016 Cycles with data_val_i low SHALL leave cnt and the shift register unchanged; gaps inside a word are allowed.
REQ-017 busy_o = (cnt != 0), registered-state-derived, with no combinational path from inputs.

Reset
REQ-018 srst_i high SHALL immediately set cnt=0, state=IDLE, shift register=0, data_o=0, data_val_o=0, and busy_o=0 (plus data_len_o=0 when present).
REQ-019 Reset mid-word SHALL discard the partial word with no data_val_o; the first bit accepted after release is bit 1 of a new word.

Configuration
REQ-020 Macro DESERIALIZER_FLUSH_EN defined: add input flush_i (1 bit) and output data_len_o ($clog2(WIDTH)+1 bits). flush_i high in COLLECT emits the partial word next cycle with data_val_o=1 and data_len_o=bit count. Data is left-justified with zero fill for MSB_FIRST=1, right-justified for MSB_FIRST=0, and the FSM returns to IDLE.
REQ-021 flush_i together with data_val_i SHALL include that bit before flushing; if that bit completes the word, a normal full word is emitted with data_len_o=WIDTH.
REQ-022 flush_i in IDLE with data_val_i low SHALL be ignored (no strobe). With the macro, every full word reports data_len_o=WIDTH.
REQ-023 Macro undefined: flush_i and data_len_o do not exist, and only full words are emitted.

Structure
REQ-024 Package deserializer_pkg SHALL hold the FSM state enum typedef (IDLE, COLLECT) and localparam DESER_DEFAULT_WIDTH=32.
REQ-025 One sub-module, deserializer_shift_reg (parameterised WIDTH, MSB_FIRST; shift, clear, and justify on flush), is natural; the counter and FSM stay in the top.

Verification
REQ-026 WIDTH=32, MSB_FIRST=1: 32 consecutive bits 0x8000_0001 MSB-first -> data_o=0x8000_0001 and data_val_o high exactly 1 cycle after the last bit; feeding bit_population_counter yields 2.
REQ-027 Two back-to-back words 0xFFFF_FFFF then 0x0000_0000, no gaps -> two strobes exactly 32 cycles apart with the correct words.
REQ-028 Same word sent with random data_val_i gaps (~50% duty) -> identical data_o, and no strobe before bit 32.
REQ-029 srst_i pulsed after 17 bits, then full word 0x1234_5678 -> no strobe for the partial word; next strobe shows data_o=0x1234_5678.
REQ-030 MSB_FIRST=0: bits 1,0,0,…0 -> data_o=0x0000_0001.
REQ-031 DESERIALIZER_FLUSH_EN defined: 5 bits 1,0,1,1,0 then flush_i -> data_o=0xB000_0000, data_len_o=5, busy_o falls; flush_i in IDLE -> no strobe.
